// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//
// Load/store bridge between the core's byte-addressed memory port and a
// word-aligned 32-bit request/grant data bus with byte strobes.
//
// The core raises memory_en with a request (store_size, mem_addr,
// mem_write_data) and holds it until the bridge completes the access:
//   - loads  complete with a one-cycle mem_read_data_valid pulse, with
//            mem_read_data shifted so the addressed byte/half sits at bit 0;
//   - stores complete with a one-cycle mem_write_ready pulse.
// Misaligned stores are dropped without touching the bus, and accesses that
// stall on the bus for TIMEOUT_CYCLES are aborted. Both still complete
// (with misalign_err / timeout_err alongside the completion pulse) so the
// core can never hang on the bridge.
//
// Ports
//   CLK, resetn          clock (rising edge), asynchronous active-low reset
//   memory_en            core request, held until completion
//   store_size           00=SB, 01=SH, 10=SW, 11=load
//   mem_addr             byte address
//   mem_write_data       store data, right-justified
//   mem_read_data        lane-aligned load data (held until next load)
//   mem_read_data_valid  one-cycle load completion pulse
//   mem_write_ready      one-cycle store completion pulse
//   bus_req              bus request, held in ADDR until bus_gnt
//   bus_we               1=write, 0=read
//   bus_addr             word-aligned address
//   bus_wstrb            byte enables (0000 for reads)
//   bus_wdata            lane-replicated store data
//   bus_gnt              bus accepts the request this cycle
//   bus_rvalid           read data valid
//   bus_rdata            read data word
//   misalign_err         one-cycle pulse: misaligned store dropped
//   timeout_err          one-cycle pulse: access aborted by timeout
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in ADDR+RDATA before abort (>= 2)
//   CNT_W           timeout counter width, must hold TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module data_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        memory_en,
  input  logic [1:0]  store_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_read_data_valid,
  output logic        mem_write_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        misalign_err,
  output logic        timeout_err
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [1:0] SZ_LOAD = 2'b11;

  // Last counter value allowed before the access is aborted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Request decode (combinational on the core's inputs; only used in IDLE)
  // ---------------------------------------------------------------------------
  logic        req_is_load;
  logic        req_misalign;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;

  assign req_is_load = (store_size == SZ_LOAD);

  // Loads carry no width, so only stores are alignment-checked; a byte store
  // can never be misaligned.
  assign req_misalign = ((store_size == SZ_H) && mem_addr[0]) ||
                        ((store_size == SZ_W) && (mem_addr[1:0] != 2'b00));

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    req_wstrb = 4'b0000;
    req_wdata = 32'h0000_0000;
    case (store_size)
      SZ_B: begin
        req_wstrb = 4'b0001 << mem_addr[1:0];
        req_wdata = {4{mem_write_data[7:0]}};
      end
      SZ_H: begin
        // Half stores use the upper or lower half-word lane pair only.
        req_wstrb = 4'b0011 << {mem_addr[1], 1'b0};
        req_wdata = {2{mem_write_data[15:0]}};
      end
      SZ_W: begin
        req_wstrb = 4'b1111;
        req_wdata = mem_write_data;
      end
      default: begin
        // Loads: no strobes, no write data.
        req_wstrb = 4'b0000;
        req_wdata = 32'h0000_0000;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured request and datapath state
  // ---------------------------------------------------------------------------
  logic             is_load_q;   // type of the access in flight (selects pulse)
  logic [1:0]       offset_q;    // byte offset used to align load data
  logic [CNT_W-1:0] cnt_q;       // cycles spent in ADDR+RDATA
  logic             misalign_q;
  logic             timeout_q;

  logic             bus_we_q;
  logic [31:0]      bus_addr_q;
  logic [3:0]       bus_wstrb_q;
  logic [31:0]      bus_wdata_q;
  logic [31:0]      rd_data_q;

  // Control strobes from the FSM
  logic capture;       // accept the request presented in IDLE
  logic capture_bus;   // also latch bus-side fields (aligned accesses only)
  logic set_misalign;
  logic set_timeout;
  logic rdata_load;
  logic rdata_clr;
  logic cnt_clr;
  logic cnt_inc;
  logic timeout_hit;

  assign timeout_hit = (cnt_q >= CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    capture_bus  = 1'b0;
    set_misalign = 1'b0;
    set_timeout  = 1'b0;
    rdata_load   = 1'b0;
    rdata_clr    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (memory_en) begin
          capture = 1'b1;
          if (!req_is_load && req_misalign) begin
            // Dropped without any bus activity; completes next cycle.
            set_misalign = 1'b1;
            rdata_clr    = 1'b1;
            state_d      = RESP;
          end else begin
            capture_bus = 1'b1;
            cnt_clr     = 1'b1;
            state_d     = ADDR;
          end
        end
      end

      ADDR: begin
        cnt_inc = 1'b1;
        // Grant wins over a timeout landing on the same cycle. Any
        // bus_rvalid seen here belongs to someone else and is ignored.
        if (bus_gnt) begin
          state_d = bus_we_q ? RESP : RDATA;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          rdata_clr   = 1'b1;
          state_d     = RESP;
        end
      end

      RDATA: begin
        cnt_inc = 1'b1;
        if (bus_rvalid) begin
          rdata_load = 1'b1;
          state_d    = RESP;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          rdata_clr   = 1'b1;
          state_d     = RESP;
        end
      end

      RESP: begin
        // memory_en is deliberately not looked at here: the core only
        // advances on this edge, so sampling it now would re-issue the
        // access that is just completing.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      is_load_q <= 1'b0;
      offset_q  <= 2'b00;
    end else if (capture) begin
      is_load_q <= req_is_load;
      offset_q  <= mem_addr[1:0];
    end
  end

  // Bus-side fields only move for accesses that actually go to the bus, so
  // a dropped misaligned store leaves the bus outputs untouched.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_wstrb_q <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
    end else if (capture_bus) begin
      bus_we_q    <= !req_is_load;
      bus_addr_q  <= {mem_addr[31:2], 2'b00};
      bus_wstrb_q <= req_wstrb;
      bus_wdata_q <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data: aligned on capture, cleared by an aborted/dropped access,
  // otherwise held so the core can read it after the valid pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rd_data_q <= 32'h0000_0000;
    end else if (rdata_load) begin
      rd_data_q <= bus_rdata >> {offset_q, 3'b000};
    end else if (rdata_clr) begin
      rd_data_q <= 32'h0000_0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Error pulses: registered on the transition into RESP, so they are high
  // for exactly the RESP cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      misalign_q <= set_misalign;
      timeout_q  <= set_timeout;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // bus_req and the completion pulses decode the state register directly, so
  // an asynchronous reset drops them in the same instant it is applied.
  assign bus_req             = (state_q == ADDR);
  assign bus_we              = bus_we_q;
  assign bus_addr            = bus_addr_q;
  assign bus_wstrb           = bus_wstrb_q;
  assign bus_wdata           = bus_wdata_q;

  assign mem_read_data       = rd_data_q;
  assign mem_read_data_valid = (state_q == RESP) &&  is_load_q;
  assign mem_write_ready     = (state_q == RESP) && !is_load_q;

  assign misalign_err        = misalign_q;
  assign timeout_err         = timeout_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_mem_bridge
//
// Self-checking bench for data_mem_bridge. Two instances share clock and
// reset: dut (default timeout) for the functional scenarios and dut_to
// (TIMEOUT_CYCLES=4) for the timeout scenarios. Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the active edge.
// Expected completions are queued when a request is driven and popped when
// the bridge signals completion.
// -----------------------------------------------------------------------------
module tb_data_mem_bridge;

  // Clock / reset
  logic CLK;
  logic resetn;

  // Main instance
  logic        mem_en;
  logic [1:0]  store_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd;
  logic        rd_valid;
  logic        wr_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        mis_err;
  logic        to_err;

  // Timeout instance
  logic        t_mem_en;
  logic [1:0]  t_size;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] t_rd;
  logic        t_rd_valid;
  logic        t_wr_ready;
  logic        t_bus_req;
  logic        t_bus_we;
  logic [31:0] t_bus_addr;
  logic [3:0]  t_bus_wstrb;
  logic [31:0] t_bus_wdata;
  logic        t_gnt;
  logic        t_rvalid;
  logic [31:0] t_rdata;
  logic        t_mis_err;
  logic        t_to_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_load;
    logic [31:0] data;      // expected mem_read_data at completion
    logic        misalign;
    logic        timeout;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] model_rd;    // expected held value of mem_read_data

  data_mem_bridge dut (
    .CLK                 (CLK),
    .resetn              (resetn),
    .memory_en           (mem_en),
    .store_size          (store_size),
    .mem_addr            (addr),
    .mem_write_data      (wdata),
    .mem_read_data       (rd),
    .mem_read_data_valid (rd_valid),
    .mem_write_ready     (wr_ready),
    .bus_req             (bus_req),
    .bus_we              (bus_we),
    .bus_addr            (bus_addr),
    .bus_wstrb           (bus_wstrb),
    .bus_wdata           (bus_wdata),
    .bus_gnt             (gnt),
    .bus_rvalid          (rvalid),
    .bus_rdata           (rdata),
    .misalign_err        (mis_err),
    .timeout_err         (to_err)
  );

  data_mem_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut_to (
    .CLK                 (CLK),
    .resetn              (resetn),
    .memory_en           (t_mem_en),
    .store_size          (t_size),
    .mem_addr            (t_addr),
    .mem_write_data      (t_wdata),
    .mem_read_data       (t_rd),
    .mem_read_data_valid (t_rd_valid),
    .mem_write_ready     (t_wr_ready),
    .bus_req             (t_bus_req),
    .bus_we              (t_bus_we),
    .bus_addr            (t_bus_addr),
    .bus_wstrb           (t_bus_wstrb),
    .bus_wdata           (t_bus_wdata),
    .bus_gnt             (t_gnt),
    .bus_rvalid          (t_rvalid),
    .bus_rdata           (t_rdata),
    .misalign_err        (t_mis_err),
    .timeout_err         (t_to_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push_exp(input logic is_load, input logic [31:0] data,
                          input logic misalign, input logic timeout);
    resp_t e;
    e.is_load  = is_load;
    e.data     = data;
    e.misalign = misalign;
    e.timeout  = timeout;
    exp_q.push_back(e);
  endtask

  task automatic start_req(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
    mem_en     = 1'b1;
    store_size = sz;
    addr       = a;
    wdata      = d;
  endtask

  // Waits (bounded) for a completion pulse on the main instance, pops the
  // scoreboard and compares, then releases the request and confirms the
  // pulse lasted a single cycle.
  task automatic wait_resp(input int max_wait, input string name);
    resp_t e;
    int    n = 0;
    while (!(rd_valid || wr_ready) && n < max_wait) begin
      tick();
      n++;
    end
    n_checks++;
    if (!(rd_valid || wr_ready)) begin
      n_fail++;
      $display("FAIL %s completion: no pulse after %0d cycles (expected within %0d)",
               name, n, max_wait);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s completion: unexpected pulse valid=%b ready=%b, nothing queued",
               name, rd_valid, wr_ready);
    end else begin
      e = exp_q.pop_front();
      if ({rd_valid, wr_ready, mis_err, to_err} !==
          {e.is_load, !e.is_load, e.misalign, e.timeout}) begin
        n_fail++;
        $display("FAIL %s flags: got valid/ready/mis/to=%b%b%b%b expected %b%b%b%b",
                 name, rd_valid, wr_ready, mis_err, to_err,
                 e.is_load, !e.is_load, e.misalign, e.timeout);
      end
      n_checks++;
      if (rd !== e.data) begin
        n_fail++;
        $display("FAIL %s mem_read_data: got %h expected %h", name, rd, e.data);
      end
    end
    mem_en = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    tick();
    n_checks++;
    if ({rd_valid, wr_ready, mis_err, to_err, bus_req} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s single pulse: got valid/ready/mis/to/req=%b%b%b%b%b expected 00000",
               name, rd_valid, wr_ready, mis_err, to_err, bus_req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({rd, rd_valid, wr_ready, bus_req, bus_we, bus_addr, bus_wstrb,
         bus_wdata, mis_err, to_err} !== '0) begin
      n_fail++;
      $display("FAIL reset main outputs: req=%b we=%b addr=%h strb=%b wdata=%h rd=%h expected all 0",
               bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, rd);
    end
    n_checks++;
    if ({t_rd, t_rd_valid, t_wr_ready, t_bus_req, t_bus_we, t_bus_addr,
         t_bus_wstrb, t_bus_wdata, t_mis_err, t_to_err} !== '0) begin
      n_fail++;
      $display("FAIL reset timeout-instance outputs: req=%b rd=%h expected all 0",
               t_bus_req, t_rd);
    end
    resetn   = 1'b1;
    model_rd = 32'h0;
    tick();
  endtask

  task automatic test_store_word();
    push_exp(1'b0, model_rd, 1'b0, 1'b0);
    start_req(2'b10, 32'h0000_0100, 32'hCAFE_BABE);
    tick();  // cycle 1: ADDR
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata} !==
        {1'b1, 1'b1, 32'h0000_0100, 4'b1111, 32'hCAFE_BABE}) begin
      n_fail++;
      $display("FAIL sw bus: req=%b we=%b addr=%h strb=%b wdata=%h expected 1 1 00000100 1111 cafebabe",
               bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata);
    end
    gnt = 1'b1;
    tick();  // cycle 2: RESP
    wait_resp(0, "sw");
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  strb;
    logic [31:0] wd;
  } lane_t;

  task automatic test_store_lanes();
    lane_t tbl[5];
    tbl[0] = '{sz: 2'b00, a: 32'h0000_0103, d: 32'h0000_00A5, strb: 4'b1000, wd: 32'hA5A5_A5A5};
    tbl[1] = '{sz: 2'b01, a: 32'h0000_0102, d: 32'h0000_1234, strb: 4'b1100, wd: 32'h1234_1234};
    tbl[2] = '{sz: 2'b00, a: 32'h0000_0201, d: 32'hFFFF_FF3C, strb: 4'b0010, wd: 32'h3C3C_3C3C};
    tbl[3] = '{sz: 2'b01, a: 32'h0000_0200, d: 32'hABCD_5678, strb: 4'b0011, wd: 32'h5678_5678};
    tbl[4] = '{sz: 2'b10, a: 32'h0000_0104, d: 32'h0123_4567, strb: 4'b1111, wd: 32'h0123_4567};
    for (int i = 0; i < 5; i++) begin
      push_exp(1'b0, model_rd, 1'b0, 1'b0);
      start_req(tbl[i].sz, tbl[i].a, tbl[i].d);
      tick();
      n_checks++;
      if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata} !==
          {1'b1, 1'b1, tbl[i].a & 32'hFFFF_FFFC, tbl[i].strb, tbl[i].wd}) begin
        n_fail++;
        $display("FAIL lane[%0d] bus: req=%b we=%b addr=%h strb=%b wdata=%h expected 1 1 %h %b %h",
                 i, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
                 tbl[i].a & 32'hFFFF_FFFC, tbl[i].strb, tbl[i].wd);
      end
      gnt = 1'b1;
      tick();
      wait_resp(0, "lane store");
    end
  endtask

  task automatic test_load_delayed();
    model_rd = 32'h8899_AABB >> 16;  // offset 2
    push_exp(1'b1, model_rd, 1'b0, 1'b0);
    start_req(2'b11, 32'h0000_0202, 32'h0);
    tick();  // N1: ADDR
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_wstrb} !== {1'b1, 1'b0, 32'h0000_0200, 4'b0000}) begin
      n_fail++;
      $display("FAIL load bus: req=%b we=%b addr=%h strb=%b expected 1 0 00000200 0000",
               bus_req, bus_we, bus_addr, bus_wstrb);
    end
    tick();  // N2: stray rvalid while still in ADDR
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    tick();  // N3
    rvalid = 1'b0;
    n_checks++;
    if ({bus_req, rd_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL load rvalid-in-addr: req=%b valid=%b expected 1 0", bus_req, rd_valid);
    end
    tick();  // N4: grant now
    gnt = 1'b1;
    tick();  // N5: RDATA
    gnt = 1'b0;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL load rdata req: got %b expected 0", bus_req);
    end
    tick();  // N6: data two cycles after grant
    rvalid = 1'b1;
    rdata  = 32'h8899_AABB;
    tick();  // N7: RESP
    wait_resp(0, "load delayed");
  endtask

  task automatic test_load_misaligned();
    model_rd = 32'h1122_3344 >> 24;  // offset 3
    push_exp(1'b1, model_rd, 1'b0, 1'b0);
    start_req(2'b11, 32'h0000_0203, 32'h0);
    tick();  // cycle 1: ADDR, zero-wait grant
    gnt = 1'b1;
    tick();  // cycle 2: RDATA
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h1122_3344;
    tick();  // cycle 3: RESP
    wait_resp(0, "load misaligned");
  endtask

  task automatic test_misaligned_store();
    logic [31:0] mis_addr [2];
    logic [1:0]  mis_sz   [2];
    mis_addr[0] = 32'h0000_0101; mis_sz[0] = 2'b10;
    mis_addr[1] = 32'h0000_0105; mis_sz[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      model_rd = 32'h0;
      push_exp(1'b0, model_rd, 1'b1, 1'b0);
      start_req(mis_sz[i], mis_addr[i], 32'hFFFF_FFFF);
      tick();  // cycle 1: RESP directly
      n_checks++;
      if (bus_req !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign[%0d] bus_req: got %b expected 0", i, bus_req);
      end
      wait_resp(0, "misaligned store");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [2];
    resp_t       e;
    int          acc      = 0;
    int          vcnt     = 0;
    int          first_v  = -1;
    int          second_a = -1;
    logic        pend     = 1'b0;
    words[0] = 32'hA1B2_C3D4;
    words[1] = 32'h0102_0304;
    push_exp(1'b1, words[0], 1'b0, 1'b0);
    push_exp(1'b1, words[1] >> 8, 1'b0, 1'b0);
    model_rd = words[1] >> 8;
    start_req(2'b11, 32'h0000_0500, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (rd_valid) begin
        vcnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b extra valid at cycle %0d, expected none", c);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.data) begin
            n_fail++;
            $display("FAIL b2b data[%0d]: got %h expected %h", vcnt, rd, e.data);
          end
        end
        if (vcnt == 1) begin
          first_v = c;
          addr    = 32'h0000_0505;  // next request, memory_en stays high
        end else begin
          mem_en = 1'b0;
        end
      end
      rvalid = 1'b0;
      if (pend) begin
        rvalid = 1'b1;
        rdata  = words[(acc - 1) & 1];
        pend   = 1'b0;
      end
      if (bus_req) begin
        gnt = 1'b1;
        acc++;
        if (acc == 2) begin
          second_a = c;
          n_checks++;
          if (bus_addr !== 32'h0000_0504) begin
            n_fail++;
            $display("FAIL b2b second addr: got %h expected 00000504", bus_addr);
          end
        end
        pend = 1'b1;
      end else begin
        gnt = 1'b0;
      end
    end
    mem_en = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    n_checks++;
    if (acc !== 2 || vcnt !== 2) begin
      n_fail++;
      $display("FAIL b2b counts: acceptances=%0d valids=%0d expected 2 2", acc, vcnt);
    end
    n_checks++;
    if (second_a - first_v !== 2) begin
      n_fail++;
      $display("FAIL b2b idle gap: second grant %0d cycles after first valid, expected 2",
               second_a - first_v);
    end
    tick();
  endtask

  task automatic test_timeout();
    int hi = 0;
    // Prime mem_read_data with a normal zero-wait load.
    t_mem_en = 1'b1;
    t_size   = 2'b11;
    t_addr   = 32'h0000_0010;
    tick();
    t_gnt = 1'b1;
    tick();
    t_gnt    = 1'b0;
    t_rvalid = 1'b1;
    t_rdata  = 32'h5A5A_5A5A;
    tick();
    n_checks++;
    if ({t_rd_valid, t_rd} !== {1'b1, 32'h5A5A_5A5A}) begin
      n_fail++;
      $display("FAIL timeout prime load: valid=%b rd=%h expected 1 5a5a5a5a", t_rd_valid, t_rd);
    end
    t_mem_en = 1'b0;
    t_rvalid = 1'b0;
    tick();
    // Load with no grant ever: abort after 4 cycles of bus_req.
    t_mem_en = 1'b1;
    t_addr   = 32'h0000_0020;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (t_bus_req) hi++;
    end
    n_checks++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL timeout req cycles: got %0d expected 4", hi);
    end
    tick();
    n_checks++;
    if ({t_bus_req, t_rd_valid, t_wr_ready, t_mis_err, t_to_err} !== 5'b01001) begin
      n_fail++;
      $display("FAIL timeout resp: req/valid/ready/mis/to=%b%b%b%b%b expected 01001",
               t_bus_req, t_rd_valid, t_wr_ready, t_mis_err, t_to_err);
    end
    n_checks++;
    if (t_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout rd: got %h expected 00000000", t_rd);
    end
    t_mem_en = 1'b0;
    tick();
    n_checks++;
    if ({t_rd_valid, t_to_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout pulse width: valid=%b to=%b expected 0 0", t_rd_valid, t_to_err);
    end
    // Store granted on the final allowed cycle: grant wins, no error.
    t_mem_en = 1'b1;
    t_size   = 2'b10;
    t_addr   = 32'h0000_0040;
    t_wdata  = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (t_bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout last-cycle req: got %b expected 1", t_bus_req);
    end
    t_gnt = 1'b1;
    tick();
    n_checks++;
    if ({t_bus_req, t_rd_valid, t_wr_ready, t_mis_err, t_to_err} !== 5'b00100) begin
      n_fail++;
      $display("FAIL timeout gnt priority: req/valid/ready/mis/to=%b%b%b%b%b expected 00100",
               t_bus_req, t_rd_valid, t_wr_ready, t_mis_err, t_to_err);
    end
    t_mem_en = 1'b0;
    t_gnt    = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    start_req(2'b11, 32'h0000_0300, 32'h0);
    tick();  // ADDR
    gnt = 1'b1;
    tick();  // RDATA
    gnt = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({rd, rd_valid, wr_ready, bus_req, bus_we, bus_addr, bus_wstrb,
         bus_wdata, mis_err, to_err} !== '0) begin
      n_fail++;
      $display("FAIL mid reset outputs: req=%b addr=%h rd=%h valid=%b expected all 0",
               bus_req, bus_addr, rd, rd_valid);
    end
    exp_q.delete();
    model_rd = 32'h0;
    tick();
    resetn = 1'b1;
    mem_en = 1'b0;
    rvalid = 1'b1;            // late data from the abandoned read
    rdata  = 32'hFFFF_FFFF;
    tick();
    rvalid = 1'b0;
    n_checks++;
    if ({rd_valid, bus_req, rd} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL late rvalid: valid=%b req=%b rd=%h expected 0 0 00000000",
               rd_valid, bus_req, rd);
    end
    push_exp(1'b0, model_rd, 1'b0, 1'b0);
    start_req(2'b10, 32'h0000_0400, 32'h55AA_55AA);
    tick();
    n_checks++;
    if ({bus_req, bus_addr, bus_wdata} !== {1'b1, 32'h0000_0400, 32'h55AA_55AA}) begin
      n_fail++;
      $display("FAIL post-reset store bus: req=%b addr=%h wdata=%h expected 1 00000400 55aa55aa",
               bus_req, bus_addr, bus_wdata);
    end
    gnt = 1'b1;
    tick();
    wait_resp(0, "post-reset store");
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin
    resetn     = 1'b0;
    mem_en     = 1'b0;
    store_size = 2'b00;
    addr       = 32'h0;
    wdata      = 32'h0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    rdata      = 32'h0;
    t_mem_en   = 1'b0;
    t_size     = 2'b00;
    t_addr     = 32'h0;
    t_wdata    = 32'h0;
    t_gnt      = 1'b0;
    t_rvalid   = 1'b0;
    t_rdata    = 32'h0;
    model_rd   = 32'h0;

    test_reset();
    test_store_word();
    test_store_lanes();
    test_load_delayed();
    test_load_misaligned();
    test_misaligned_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

endmodule
